axi_lite_read_slave: RTL and testbench
======================================

Name: axi_lite_read_slave

Overview:
- AXI4-Lite read-channel responder: the read-side counterpart of the team's write address master/slave pair.
- Accepts a read address on the AR channel and fetches one word from a register bank through a synchronous read port.
- Returns the word and a response on the R channel.
- One outstanding transaction; sits between the interconnect and the peripheral register bank.

Parameters:
ADDR_W, 32, AR address width
DATA_W, 32, RDATA / register width
NUM_REGS, 16, number of word registers decoded (power of 2, >=2)

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETn  in  1  asynchronous active-low reset
ARVALID  in  1  master address valid
ARREADY  out  1  slave ready to accept address
ARADDR  in  ADDR_W  byte address
ARPROT  in  3  protection attributes; accepted, not used
RVALID  out  1  read data valid
RREADY  in  1  master ready for data
RDATA  out  DATA_W  read data
RRESP  out  2  response, OKAY=2'b00, SLVERR=2'b10
reg_rd_en  out  1  one-cycle read strobe to register bank
reg_rd_idx  out  log2(NUM_REGS)  word index to register bank
reg_rd_data  in  DATA_W  bank data, valid the cycle after reg_rd_en

Behaviour:
- Reset (ARESETn low, asynchronous): state=IDLE, ARREADY=0, RVALID=0, RDATA=0, RRESP=0, reg_rd_en=0, reg_rd_idx=0.
  - ARREADY rises on the first ACLK edge after release.
  - Reset mid-transaction abandons it immediately; no R beat is issued for it.
- FSM states: IDLE, RD_REQ, RD_WAIT, RESP. All outputs are registered.
- IDLE: ARREADY=1.
  - On edge with ARVALID&&ARREADY: latch ARADDR; ARREADY<=0; state RD_REQ.
  - Otherwise stay in IDLE.
- Decode:
  - idx = addr[2 +: log2(NUM_REGS)]. Bits [1:0] are ignored, so unaligned addresses read the containing word.
  - in_range = (addr >> 2) < NUM_REGS, i.e. all address bits above the index field are zero.
- RD_REQ (one cycle):
  - reg_rd_en=1 only if in_range; reg_rd_idx=idx, held stable until the next accepted address.
  - Next state RD_WAIT.
- RD_WAIT (one cycle):
  - On exit edge: RDATA<=in_range ? reg_rd_data : 0; RRESP<=in_range ? OKAY : SLVERR; RVALID<=1.
  - Next state RESP.
- RESP:
  - RVALID, RDATA and RRESP are held stable until the edge with RVALID&&RREADY.
  - On that edge: RVALID<=0, RDATA<=0, RRESP<=0, ARREADY<=1, state IDLE.
  - RREADY may be high before RVALID; the handshake then completes on the first edge RVALID is high.
- Latency:
  - AR handshake on edge E0 gives RVALID high after E2.
  - With RREADY held high, the R handshake occurs at E3 and ARREADY is high after E3.
  - Minimum spacing between accepted addresses is 4 cycles.
- ARVALID asserted while ARREADY=0 is not accepted. ARADDR is sampled only on the handshake edge.
- ARVALID may drop without a handshake; no side effect.
- No combinational path exists from any input to any output.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - read FSM state encoding (2-bit enum)
- Sub-modules: none. Single flat module.
- The bench provides a behavioural synchronous-read register bank model.

Test Plan:
1. Reset: hold ARESETn=0 with ARVALID=1 -> all outputs 0, no handshake. Release -> ARREADY=1 one edge later.
2. Single read: bank[3]=32'hDEADBEEF; ARADDR=32'h0C with RREADY=1.
   - reg_rd_en pulses one cycle with idx=3.
   - RVALID after 2 edges with RDATA=32'hDEADBEEF, RRESP=2'b00.
   - ARREADY back high after the R handshake.
3. Backpressure: as scenario 2 but RREADY=0 for 5 cycles -> RVALID/RDATA/RRESP stable all 5 cycles; R handshake completes on the first edge with RREADY=1.
4. Out of range: ARADDR=32'h40 (NUM_REGS=16) -> reg_rd_en stays 0; RDATA=0, RRESP=2'b10. Unaligned ARADDR=32'h0E -> bank[3] data, OKAY.
5. Back-to-back: ARVALID held high with addresses 0x0, 0x4, 0x8 and RREADY=1 -> three responses in order (bank[0], bank[1], bank[2]), 4 cycles apart; ARREADY=0 between accepts.
6. Reset mid-op: assert ARESETn=0 while in RESP with RREADY=0 -> RVALID drops immediately (asynchronously); after release, no stale beat appears and a new read returns correct data.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and read-FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RESP    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/axi_lite_read_slave_if.sv
// AXI4-Lite read channels (AR + R) bundled with master/slave views.
interface axi_lite_read_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [2:0]        ARPROT;
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;

    modport master (
        output ARVALID, ARADDR, ARPROT, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  ARVALID, ARADDR, ARPROT, RREADY,
        output ARREADY, RVALID, RDATA, RRESP
    );
endinterface

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read responder: one outstanding read, fetched from a register
// bank through a synchronous read port, returned on the R channel.
module axi_lite_read_slave
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    axi_lite_read_slave_if.slave        s_axi,
    output logic                        reg_rd_en,
    output logic [$clog2(NUM_REGS)-1:0] reg_rd_idx,
    input  logic [DATA_W-1:0]           reg_rd_data
);

    localparam int IDX_W = $clog2(NUM_REGS);

    rd_state_e         r_state;
    logic              r_arready;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rd_en;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_in_range;

    // Decode of the incoming address; only consumed on the AR handshake edge.
    // Bits [1:0] are dropped so unaligned addresses hit the containing word.
    logic [IDX_W-1:0]  w_ar_idx;
    logic              w_ar_in_range;

    assign w_ar_idx      = s_axi.ARADDR[2 +: IDX_W];
    assign w_ar_in_range = (s_axi.ARADDR >> (IDX_W + 2)) == '0;

    // Read FSM; every output is a register so no input reaches an output
    // combinationally. The in-range flag is captured at accept time so the
    // response phase need not keep the whole address.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= ST_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_rd_en    <= 1'b0;
            r_rd_idx   <= '0;
            r_in_range <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_arready) begin
                        r_arready <= 1'b1;
                    end else if (s_axi.ARVALID) begin
                        r_arready  <= 1'b0;
                        r_in_range <= w_ar_in_range;
                        r_rd_en    <= w_ar_in_range;
                        r_rd_idx   <= w_ar_idx;
                        r_state    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    r_state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= r_in_range ? reg_rd_data : '0;
                    r_rresp  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (s_axi.RREADY) begin
                        r_rvalid  <= 1'b0;
                        r_rdata   <= '0;
                        r_rresp   <= RESP_OKAY;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_axi.ARREADY = r_arready;
    assign s_axi.RVALID  = r_rvalid;
    assign s_axi.RDATA   = r_rdata;
    assign s_axi.RRESP   = r_rresp;
    assign reg_rd_en     = r_rd_en;
    assign reg_rd_idx    = r_rd_idx;

endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Directed bench for axi_lite_read_slave with a synchronous-read bank model.
module tb_axi_lite_read_slave;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    logic              ACLK;
    logic              ARESETn;
    logic              reg_rd_en;
    logic [3:0]        reg_rd_idx;
    logic [DATA_W-1:0] reg_rd_data;

    axi_lite_read_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axi_lite_read_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .s_axi       (axi),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_idx  (reg_rd_idx),
        .reg_rd_data (reg_rd_data)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Synchronous-read register bank: data appears the cycle after the strobe.
    logic [DATA_W-1:0] bank [NUM_REGS];
    logic [DATA_W-1:0] bank_q;
    always @(posedge ACLK) if (reg_rd_en) bank_q <= bank[reg_rd_idx];
    assign reg_rd_data = bank_q;

    // Handshake monitor: values read here are the pre-edge ones.
    int          cyc = 0;
    int          n_acc = 0;
    int          n_beat = 0;
    int          acc_cyc[$];
    int          beat_cyc[$];
    logic [31:0] beat_d[$];
    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (ARESETn && axi.ARVALID && axi.ARREADY) begin
            n_acc++;
            acc_cyc.push_back(cyc);
        end
        if (axi.RVALID && axi.RREADY) begin
            n_beat++;
            beat_cyc.push_back(cyc);
            beat_d.push_back(axi.RDATA);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One read; hold = cycles RREADY stays low once RVALID is up.
    task automatic rd(input logic [31:0] addr, input int hold, input logic [31:0] exp_d,
                      input logic [1:0] exp_r, input logic exp_en, input logic [3:0] exp_idx);
        int n;
        int lat;
        int a0;
        int b0;
        a0 = n_acc;
        axi.RREADY  = (hold == 0);
        axi.ARADDR  = addr;
        axi.ARVALID = 1'b1;
        n = 0;
        do begin @(negedge ACLK); n++; end while (n_acc == a0 && n < 10);
        axi.ARVALID = 1'b0;
        chk("accept", 64'(n_acc - a0), 1);
        chk("rd_en", reg_rd_en, exp_en);
        chk("rd_idx", reg_rd_idx, exp_idx);
        chk("arready_lo", axi.ARREADY, 0);
        @(negedge ACLK);
        chk("rd_en_pulse", reg_rd_en, 0);
        lat = 1;
        while (!axi.RVALID && lat < 10) begin @(negedge ACLK); lat++; end
        chk("rvalid_lat", 64'(lat), 2);
        chk("rdata", axi.RDATA, exp_d);
        chk("rresp", axi.RRESP, exp_r);
        for (int i = 0; i < hold; i++) begin
            @(negedge ACLK);
            chk("hold_v", axi.RVALID, 1);
            chk("hold_d", axi.RDATA, exp_d);
            chk("hold_r", axi.RRESP, exp_r);
        end
        axi.RREADY = 1'b1;
        b0 = n_beat;
        @(negedge ACLK);
        chk("r_hs", 64'(n_beat - b0), 1);
        chk("rvalid_lo", axi.RVALID, 0);
        chk("arready_hi", axi.ARREADY, 1);
        chk("rdata_clr", axi.RDATA, 0);
    endtask

    initial begin
        int n;
        int a0;
        int b0;
        for (int i = 0; i < NUM_REGS; i++) bank[i] = 32'h0100_0000 * i;
        bank[0] = 32'h1111_1111;
        bank[1] = 32'h2222_2222;
        bank[2] = 32'h3333_3333;
        bank[3] = 32'hDEAD_BEEF;
        bank[5] = 32'hA5A5_5A5A;

        // Reset with ARVALID asserted: nothing accepted, all outputs low.
        ARESETn     = 1'b0;
        axi.ARVALID = 1'b1;
        axi.ARADDR  = 32'h0C;
        axi.ARPROT  = 3'b000;
        axi.RREADY  = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_arready", axi.ARREADY, 0);
        chk("rst_rvalid", axi.RVALID, 0);
        chk("rst_rdata", axi.RDATA, 0);
        chk("rst_rresp", axi.RRESP, 0);
        chk("rst_rd_en", reg_rd_en, 0);
        chk("rst_rd_idx", reg_rd_idx, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("rel_arready", axi.ARREADY, 1);
        chk("rel_no_acc", 64'(n_acc), 0);
        axi.ARVALID = 1'b0;
        @(negedge ACLK);

        // Single read, backpressure, out of range, unaligned.
        rd(32'h0C, 0, 32'hDEAD_BEEF, 2'b00, 1'b1, 4'd3);
        rd(32'h0C, 5, 32'hDEAD_BEEF, 2'b00, 1'b1, 4'd3);
        rd(32'h40, 0, 32'h0,         2'b10, 1'b0, 4'd0);
        rd(32'h0E, 0, 32'hDEAD_BEEF, 2'b00, 1'b1, 4'd3);

        // Back-to-back with ARVALID held high.
        acc_cyc.delete(); beat_cyc.delete(); beat_d.delete();
        axi.RREADY  = 1'b1;
        axi.ARADDR  = 32'h0;
        axi.ARVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a0 = n_acc;
            n  = 0;
            while (n_acc == a0 && n < 12) begin @(negedge ACLK); n++; end
            chk("b2b_acc", 64'(n_acc - a0), 1);
            axi.ARADDR = 32'(4 * (k + 1));
            if (k == 2) axi.ARVALID = 1'b0;
        end
        repeat (6) @(negedge ACLK);
        chk("b2b_nbeat", 64'(beat_d.size()), 3);
        if (beat_d.size() == 3 && acc_cyc.size() == 3) begin
            chk("b2b_d0", beat_d[0], 32'h1111_1111);
            chk("b2b_d1", beat_d[1], 32'h2222_2222);
            chk("b2b_d2", beat_d[2], 32'h3333_3333);
            chk("b2b_acc_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 4);
            chk("b2b_acc_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 4);
            chk("b2b_beat_gap1", 64'(beat_cyc[1] - beat_cyc[0]), 4);
            chk("b2b_beat_gap2", 64'(beat_cyc[2] - beat_cyc[1]), 4);
            chk("b2b_first_lat", 64'(beat_cyc[0] - acc_cyc[0]), 3);
        end

        // Reset while holding a response: beat is abandoned.
        axi.RREADY  = 1'b0;
        axi.ARADDR  = 32'h4;
        axi.ARVALID = 1'b1;
        a0 = n_acc;
        n  = 0;
        while (n_acc == a0 && n < 10) begin @(negedge ACLK); n++; end
        axi.ARVALID = 1'b0;
        n = 0;
        while (!axi.RVALID && n < 10) begin @(negedge ACLK); n++; end
        chk("mid_rvalid_up", axi.RVALID, 1);
        ARESETn = 1'b0;
        #1;
        chk("mid_rvalid_async", axi.RVALID, 0);
        chk("mid_rdata_async", axi.RDATA, 0);
        b0 = n_beat;
        a0 = n_acc;
        axi.RREADY = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (6) @(negedge ACLK);
        chk("mid_no_stale", 64'(n_beat - b0), 0);
        chk("mid_no_acc", 64'(n_acc - a0), 0);
        rd(32'h14, 0, 32'hA5A5_5A5A, 2'b00, 1'b1, 4'd5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
